// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversample ratio
// and the 3-sample majority vote used for mid-bit decisions.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, plus one extra
// register holding the previous synchronized value for edge detection.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk_baud,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_prev
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Reset to the idle-high line level so release never looks like a start edge.
  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_prev = prev_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 framing, majority-voted mid-bit sampling,
// one-cycle rx_valid / frame_err pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk_baud,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] MID_LO   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] MID_HI   = CW'(OVERSAMPLE / 2 + 1);

  logic rx_s;
  logic rx_prev;

  rx_state_e     state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [2:0]    bit_idx_q,   bit_idx_d;
  logic [7:0]    shift_q,     shift_d;
  logic [7:0]    rx_byte_q,   rx_byte_d;
  logic          rx_valid_q,  rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          samp_a_q,    samp_a_d;
  logic          samp_b_q,    samp_b_d;

  logic decide;
  logic bit_now;

  uart_rx_sync u_sync (
    .clk_baud (clk_baud),
    .rst      (rst),
    .rx       (rx),
    .rx_s     (rx_s),
    .rx_prev  (rx_prev)
  );

  // The first two votes are registered; the third is the live rx_s in the
  // decision cycle, so the decision lands exactly at cnt = M+1.
  assign decide  = (cnt_q == MID_HI);
  assign bit_now = maj3(samp_a_q, samp_b_q, rx_s);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    samp_a_d    = samp_a_q;
    samp_b_d    = samp_b_q;

    if (state_q != ST_IDLE) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      if (cnt_q == MID_LO) samp_a_d = rx_s;
      if (cnt_q == MID)    samp_b_d = rx_s;
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (decide) begin
          if (!bit_now) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end

      ST_DATA: begin
        if (decide) begin
          shift_d   = {bit_now, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        // Leaving at mid-stop leaves half a bit to spot a back-to-back start edge.
        if (decide) begin
          if (bit_now) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      samp_a_q    <= 1'b1;
      samp_b_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      samp_a_q    <= samp_a_d;
      samp_b_q    <= samp_b_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVERSAMPLE=16: clean, back-to-back, false
// start, framing error, glitch and mid-frame reset scenarios.
module tb_uart_rx;

  logic       clk_baud = 1'b0;
  logic       rst      = 1'b0;
  logic       rx       = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  int unsigned cyc = 0;
  int unsigned valid_cnt = 0;
  int unsigned ferr_cnt = 0;
  int unsigned both_cnt = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned last_ferr_cyc = 0;
  int unsigned start_cyc = 0;
  logic [7:0]  got_q[$];

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk_baud  (clk_baud),
    .rst       (rst),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_baud = ~clk_baud;

  always @(posedge clk_baud) cyc <= cyc + 1;

  always @(negedge clk_baud) begin
    if (rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      got_q.push_back(rx_byte);
    end
    if (frame_err) begin
      ferr_cnt++;
      last_ferr_cyc = cyc;
    end
    if (rx_valid && frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int unsigned n);
    rx = v;
    repeat (n) begin
      @(posedge clk_baud);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(d[i], 16);
    drive(stop, 16);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk_baud);
    #1;
    chk("rst_rx_byte",   32'(rx_byte),   32'h00);
    chk("rst_rx_valid",  32'(rx_valid),  32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    rst = 1'b1;
    drive(1'b1, 8);

    // Clean 0x55
    send_frame(8'h55, 1'b1);
    drive(1'b1, 4);
    chk("f55_valid_cnt", valid_cnt, 1);
    chk("f55_byte",      32'(rx_byte), 32'h55);
    chk("f55_ferr_cnt",  ferr_cnt, 0);
    chk("f55_busy",      32'(busy), 32'h0);
    chk("f55_latency",   last_valid_cyc - start_cyc, 157);

    // Back-to-back 0xA5, 0x3C
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    drive(1'b1, 4);
    chk("b2b_valid_cnt", valid_cnt, 3);
    chk("b2b_first",     32'(got_q[1]), 32'hA5);
    chk("b2b_second",    32'(got_q[2]), 32'h3C);
    chk("b2b_latency",   last_valid_cyc - start_cyc, 157);

    // False start
    drive(1'b0, 4);
    chk("fs_busy_start", 32'(busy), 32'h1);
    drive(1'b1, 20);
    chk("fs_busy_idle",  32'(busy), 32'h0);
    chk("fs_valid_cnt",  valid_cnt, 3);
    chk("fs_ferr_cnt",   ferr_cnt, 0);

    // Framing error, line held low afterwards
    send_frame(8'h0F, 1'b0);
    drive(1'b0, 40);
    chk("fe_ferr_cnt",   ferr_cnt, 1);
    chk("fe_valid_cnt",  valid_cnt, 3);
    chk("fe_byte_kept",  32'(rx_byte), 32'h3C);
    chk("fe_no_restart", 32'(busy), 32'h0);
    chk("fe_latency",    last_ferr_cyc - start_cyc, 157);
    drive(1'b1, 20);
    chk("fe_idle_busy",  32'(busy), 32'h0);

    // 0x00 with a 1-tick glitch in data bit 3
    start_cyc = cyc;
    drive(1'b0, 16);
    drive(1'b0, 48);
    drive(1'b0, 9);
    drive(1'b1, 1);
    drive(1'b0, 6);
    drive(1'b0, 64);
    drive(1'b1, 16);
    drive(1'b1, 4);
    chk("gl_valid_cnt",  valid_cnt, 4);
    chk("gl_byte",       32'(rx_byte), 32'h00);
    chk("gl_ferr_cnt",   ferr_cnt, 1);

    // Reset during data bit 4 of 0xFF, then a clean 0x81
    drive(1'b0, 16);
    drive(1'b1, 64);
    drive(1'b1, 8);
    rst = 1'b0;
    drive(1'b1, 3);
    chk("mr_busy_rst",   32'(busy), 32'h0);
    chk("mr_byte_rst",   32'(rx_byte), 32'h00);
    rst = 1'b1;
    drive(1'b1, 20);
    chk("mr_valid_cnt",  valid_cnt, 4);
    chk("mr_ferr_cnt",   ferr_cnt, 1);
    chk("mr_busy_idle",  32'(busy), 32'h0);
    send_frame(8'h81, 1'b1);
    drive(1'b1, 4);
    chk("mr_valid_after", valid_cnt, 5);
    chk("mr_byte_after",  32'(rx_byte), 32'h81);

    chk("never_both",    both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, SHALL set clk_baud ticks per serial bit; legal values are even integers >= 8.
REQ-002 clk_baud  input  1  sampling clock, SHALL run at OVERSAMPLE x bit rate.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 rx  input  1  serial line, asynchronous to clk_baud, idle high.
REQ-005 rx_byte  output  8  last correctly framed byte, LSB received first.
REQ-006 rx_valid  output  1  one-cycle pulse, rx_byte updated in the same cycle.
REQ-007 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 busy  output  1  high in every state except IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer to give rx_s; a third register SHALL hold rx_prev.
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 States SHALL be IDLE, START, DATA, STOP.
REQ-012 In IDLE, rx_prev=1 and rx_s=0 SHALL move to START with tick counter cnt=0 on the next edge.
REQ-013 cnt SHALL increment every cycle outside IDLE and wrap OVERSAMPLE-1 -> 0; M = OVERSAMPLE/2.
REQ-014 Each bit value SHALL be the majority of rx_s at cnt = M-1, M, M+1; the decision is made in the cycle with cnt = M+1.
REQ-015 START decision 0 SHALL go to DATA with bit index 0; decision 1 (false start) SHALL return to IDLE with no output pulse.
REQ-016 DATA SHALL shift each decided bit into a shift register at position 7 and shift right; after the decision for index 7 it SHALL go to STOP.
REQ-017 STOP decision 1 SHALL load rx_byte from the shift register and pulse rx_valid on the next clock edge, then go to IDLE.
REQ-018 STOP decision 0 SHALL pulse frame_err on the next clock edge, leave rx_byte unchanged, and go to IDLE.
REQ-019 Because IDLE needs a 1->0 edge, a line held low after a framing error SHALL NOT start a new frame until rx_s returns high.
REQ-020 Returning to IDLE at the stop mid-point SHALL allow a back-to-back start edge to be caught with no lost frame.
REQ-021 rx_valid and frame_err SHALL never be high in the same cycle; each SHALL be high for exactly one cycle per frame.
REQ-022 Latency SHALL be: output pulse 1 cycle after the stop-bit decision cycle.

Reset
REQ-023 While rst=0: state=IDLE, cnt=0, bit index=0, shift register=0x00, rx_byte=0x00, rx_valid=0, frame_err=0, busy=0, synchronizer and rx_prev=1.
REQ-024 Reset mid-frame SHALL abort the frame with no pulse; after release, reception SHALL resume only on a new 1->0 edge.

Structure
REQ-025 Package uart_pkg SHALL hold the rx state enum (2 bits) and the default oversample constant, shared with the UART transmitter.
REQ-026 One sub-module, uart_rx_sync, SHALL implement the 2-flop synchronizer plus rx_prev; all else SHALL stay in uart_rx.

Verification (OVERSAMPLE=16; bit = 16 ticks; decision at cnt=9)
REQ-027 Frame 0x55, ideal timing -> exactly one rx_valid with rx_byte=0x55, frame_err stays 0, busy drops after the stop decision.
REQ-028 Frames 0xA5 then 0x3C, back-to-back with no idle gap -> two rx_valid pulses, values 0xA5 then 0x3C.
REQ-029 rx low for 4 ticks then high -> START rejects the false start, no pulse, state back to IDLE.
REQ-030 Frame 0x0F with stop bit low, previous rx_byte=0x3C -> one frame_err pulse, no rx_valid, rx_byte stays 0x3C, no restart while rx is held low.
REQ-031 Frame 0x00 with a 1-tick high glitch at cnt=8 of data bit 3 -> majority rejects the glitch, rx_byte=0x00.
REQ-032 rst asserted during data bit 4 of 0xFF, released, then a clean 0x81 sent -> no pulse for the aborted frame, rx_byte=0x81 after the second frame.
